// File: rtl/frame_buffer_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter, its two clients (copy engine
// and scanout) and the single-port frame-buffer SRAM.
// Handshakes: program_write is a fire-and-forget request with no ready, and
// program_full is advisory; rd_req likewise has no ready and is answered by
// exactly one rd_valid pulse three cycles later.
interface frame_buffer_arbiter_if;
  logic        frame_sel;
  logic        program_write;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        program_full;
  logic        program_dropped;
  logic        writes_idle;
  logic        rd_req;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  modport master (
    output frame_sel, program_write, program_x, program_y, program_data,
           rd_req, rd_x, rd_y, mem_rdata,
    input  program_full, program_dropped, writes_idle, rd_valid, rd_data,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  frame_sel, program_write, program_x, program_y, program_data,
           rd_req, rd_x, rd_y, mem_rdata,
    output program_full, program_dropped, writes_idle, rd_valid, rd_data,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads win every slot, copy-engine
// writes are translated, queued in a small FIFO and drained into idle slots.
module frame_buffer_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  frame_buffer_arbiter_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0]    H_LIM = 10'(H_RES);
  localparam logic [9:0]    V_LIM = 10'(V_RES);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_t;

  function automatic logic [18:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] prod;
    if (H_RES == 640) begin
      lin_addr = ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
    end else begin
      prod     = 32'(y) * 32'(H_RES);
      lin_addr = prod[18:0] + {9'd0, x};
    end
  endfunction

  // Entry layout: {buffer bit, 19-bit linear address, 16-bit pixel}
  logic [35:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [35:0]   head;
  logic          in_range;
  logic          push;
  logic          pop;
  slot_t         slot;
  logic          rd_pipe;

  assign head = fifo_mem[rd_ptr];

  always_comb begin
    in_range = (bus.program_x < H_LIM) && (bus.program_y < V_LIM);
    // Fullness is judged on the count before this cycle's pop.
    push     = bus.program_write && in_range && (count != DEPTH);
    slot     = SLOT_IDLE;
    if (bus.rd_req) begin
      slot = SLOT_READ;
    end else if (count != '0) begin
      slot = SLOT_WRITE;
    end
    pop        = (slot == SLOT_WRITE);
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {~bus.frame_sel, lin_addr(bus.program_x, bus.program_y),
                           bus.program_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      bus.program_full    <= 1'b0;
      bus.program_dropped <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_we          <= 1'b0;
      bus.mem_re          <= 1'b0;
      rd_pipe             <= 1'b0;
      bus.rd_valid        <= 1'b0;
      bus.rd_data         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count               <= count_next;
      bus.program_full    <= (count_next == DEPTH);
      bus.program_dropped <= bus.program_write && !push;
      bus.mem_we          <= 1'b0;
      bus.mem_re          <= 1'b0;
      case (slot)
        SLOT_READ: begin
          bus.mem_re   <= 1'b1;
          bus.mem_addr <= {bus.frame_sel, lin_addr(bus.rd_x, bus.rd_y)};
        end
        SLOT_WRITE: begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= head[35:16];
          bus.mem_wdata <= head[15:0];
        end
        default: ;
      endcase
      // The SRAM answers the cycle after mem_re; capture it then.
      rd_pipe      <= bus.mem_re;
      bus.rd_valid <= rd_pipe;
      if (rd_pipe) bus.rd_data <= bus.mem_rdata;
    end
  end

  assign bus.writes_idle = (count == '0) && !bus.mem_we;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_frame_buffer_arbiter;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  frame_buffer_arbiter_if bus();

  frame_buffer_arbiter #(.H_RES(640), .V_RES(480), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [19:0] a);
    if (a == 20'hCAFFF) return 16'h1234;
    return a[15:0] ^ {a[19:16], 12'h5A5};
  endfunction

  // SRAM model: read data appears the cycle after mem_re
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem_val(bus.mem_addr);

  // reference model
  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  logic [35:0] exp_q[$];
  pend_t       pend_q[$];
  int          cyc;
  logic        exp_re, exp_we, exp_drop, exp_full, exp_idle, exp_rdv;
  logic [19:0] exp_addr;
  logic [15:0] exp_wdata, exp_rd_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      cyc = 0;
      {exp_re, exp_we, exp_drop, exp_full, exp_rdv} = '0;
      exp_idle  = 1'b1;
      exp_addr  = '0;
      exp_wdata = '0;
    end else begin
      logic in_rng;
      logic [35:0] e;
      cyc++;
      exp_rdv = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        exp_rdv     = 1'b1;
        exp_rd_data = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      in_rng   = (bus.program_x < 10'd640) && (bus.program_y < 10'd480);
      exp_drop = bus.program_write && (!in_rng || exp_q.size() == DEPTH);
      exp_re = 1'b0;
      exp_we = 1'b0;
      if (bus.rd_req) begin
        exp_re   = 1'b1;
        exp_addr = {bus.frame_sel, 19'(int'(bus.rd_y) * 640 + int'(bus.rd_x))};
        pend_q.push_back('{due: cyc + 2, data: mem_val(exp_addr)});
      end else if (exp_q.size() > 0) begin
        e         = exp_q.pop_front();
        exp_we    = 1'b1;
        exp_addr  = e[35:16];
        exp_wdata = e[15:0];
      end
      if (bus.program_write && !exp_drop)
        exp_q.push_back({~bus.frame_sel,
                         19'(int'(bus.program_y) * 640 + int'(bus.program_x)),
                         bus.program_data});
      exp_full = (exp_q.size() == DEPTH);
      exp_idle = (exp_q.size() == 0) && !exp_we;
    end
  end

  // compare process
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_re", bus.mem_re, exp_re);
      chk("mem_we", bus.mem_we, exp_we);
      chk("mem_addr", bus.mem_addr, exp_addr);
      if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("program_dropped", bus.program_dropped, exp_drop);
      chk("program_full", bus.program_full, exp_full);
      chk("writes_idle", bus.writes_idle, exp_idle);
      chk("rd_valid", bus.rd_valid, exp_rdv);
      if (exp_rdv) chk("rd_data", bus.rd_data, exp_rd_data);
    end
  end

  // event monitors for the hand-computed expectations
  int          we_cnt, drop_cnt, rdv_cnt;
  logic [15:0] seen_w[$];
  logic [19:0] seen_a[$];
  always @(negedge clk) begin
    if (bus.mem_we) begin
      we_cnt++;
      seen_w.push_back(bus.mem_wdata);
      seen_a.push_back(bus.mem_addr);
    end
    if (bus.program_dropped) drop_cnt++;
    if (bus.rd_valid) rdv_cnt++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_write(input logic en, input logic [9:0] x, input logic [9:0] y,
                           input logic [15:0] d);
    bus.program_write = en;
    bus.program_x     = x;
    bus.program_y     = y;
    bus.program_data  = d;
  endtask

  task automatic set_read(input logic en, input logic [9:0] x, input logic [9:0] y);
    bus.rd_req = en;
    bus.rd_x   = x;
    bus.rd_y   = y;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_we"}, bus.mem_we, 32'h0);
    chk({tag, "_mem_re"}, bus.mem_re, 32'h0);
    chk({tag, "_full"}, bus.program_full, 32'h0);
    chk({tag, "_dropped"}, bus.program_dropped, 32'h0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 32'h0);
    chk({tag, "_writes_idle"}, bus.writes_idle, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_sel = 1'b0;
    set_write(1'b0, '0, '0, '0);
    set_read(1'b0, '0, '0);
    step();
    cmp_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");

    // reset in the middle of a read
    step(); step(); step();
    rdv_cnt = 0;
    set_read(1'b1, 10'd5, 10'd5);
    step();
    set_read(1'b0, '0, '0);
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    step(); step(); step(); step();
    chk("midread_no_rd_valid", rdv_cnt, 0);
    check_reset_state("midread");

    // single write into the back buffer
    step();
    bus.frame_sel = 1'b0;
    set_write(1'b1, 10'd3, 10'd2, 16'hABCD);
    step();
    set_write(1'b0, '0, '0, '0);
    step();
    @(negedge clk);
    chk("single_mem_we", bus.mem_we, 1);
    chk("single_mem_addr", bus.mem_addr, 32'h80503);
    chk("single_mem_wdata", bus.mem_wdata, 32'hABCD);
    chk("single_idle_busy", bus.writes_idle, 0);
    step();
    @(negedge clk);
    chk("single_idle_back", bus.writes_idle, 1);

    // read latency from the far corner of the front buffer
    step();
    bus.frame_sel = 1'b1;
    set_read(1'b1, 10'd639, 10'd479);
    step();
    set_read(1'b0, '0, '0);
    @(negedge clk);
    chk("read_mem_re", bus.mem_re, 1);
    chk("read_mem_addr", bus.mem_addr, 32'hCAFFF);
    step();
    @(negedge clk);
    chk("read_not_yet", bus.rd_valid, 0);
    step();
    @(negedge clk);
    chk("read_rd_valid", bus.rd_valid, 1);
    chk("read_rd_data", bus.rd_data, 32'h1234);

    // reads starve writes; FIFO fills, overflow drops, then drains in order
    step();
    bus.frame_sel = 1'b0;
    we_cnt = 0;
    drop_cnt = 0;
    seen_w.delete();
    seen_a.delete();
    for (int i = 0; i < 12; i++) begin
      set_read(1'b1, 10'(i), 10'(i));
      if (i < 10) set_write(1'b1, 10'(i + 10), 10'(i), 16'h1000 + 16'(i));
      else        set_write(1'b0, '0, '0, '0);
      step();
    end
    set_read(1'b0, '0, '0);
    chk("prio_no_we", we_cnt, 0);
    chk("prio_full", bus.program_full, 1);
    chk("prio_drops", drop_cnt, 2);
    repeat (12) step();
    chk("drain_count", seen_w.size(), 8);
    if (seen_w.size() == 8) begin
      chk("drain_first", seen_w[0], 32'h1000);
      chk("drain_last", seen_w[7], 32'h1007);
      chk("drain_first_addr", seen_a[0], 32'h8000A);
    end
    chk("drain_not_full", bus.program_full, 0);

    // out-of-range coordinates
    we_cnt = 0;
    drop_cnt = 0;
    set_write(1'b1, 10'd640, 10'd0, 16'h5555);
    step();
    set_write(1'b1, 10'd0, 10'd480, 16'h6666);
    step();
    set_write(1'b0, '0, '0, '0);
    step(); step();
    chk("oor_drops", drop_cnt, 2);
    chk("oor_no_we", we_cnt, 0);
    chk("oor_idle", bus.writes_idle, 1);

    // simultaneous push and pop at count 4
    bus.frame_sel = 1'b1;
    seen_w.delete();
    seen_a.delete();
    for (int i = 0; i < 4; i++) begin
      set_read(1'b1, 10'd100, 10'(200 + i));
      set_write(1'b1, 10'(i), 10'd7, 16'h2000 + 16'(i));
      step();
    end
    set_read(1'b0, '0, '0);
    set_write(1'b1, 10'd4, 10'd7, 16'h2004);
    step();
    set_write(1'b0, '0, '0, '0);
    @(negedge clk);
    chk("pp_pop_oldest", bus.mem_wdata, 32'h2000);
    chk("pp_pop_addr", bus.mem_addr, 32'h01180);
    repeat (8) step();
    chk("pp_total", seen_w.size(), 5);
    if (seen_w.size() == 5) chk("pp_last", seen_w[4], 32'h2004);

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Shares the single-port frame-buffer SRAM between the VGA scanout reader and the copy engine's pixel-program stream (program_x / program_y / program_data / program_write). Scanout reads have absolute priority; copy-engine writes are address-translated, buffered in a small FIFO and drained into idle memory slots. Double buffering is handled here: scanout reads the front buffer and writes go to the back buffer, selected by frame_sel.

## Interface
- H_RES, 640: pixels per line; linear address = y*H_RES + x.
- V_RES, 480: lines per frame; coordinates at or beyond H_RES/V_RES are out of range.
- FIFO_DEPTH, 8: write-FIFO entries (power of two).
- clk  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_sel  in  1  front-buffer index; scanout reads buffer frame_sel, writes go to buffer ~frame_sel.
- program_write  in  1  one pixel write request per cycle asserted.
- program_x  in  10  pixel x.
- program_y  in  10  pixel y.
- program_data  in  16  pixel value.
- program_full  out  1  registered; FIFO holds FIFO_DEPTH entries.
- program_dropped  out  1  one-cycle pulse; a write was discarded.
- writes_idle  out  1  FIFO empty and no write issued this cycle.
- rd_req  in  1  scanout read request, one pixel.
- rd_x  in  10  scanout x.
- rd_y  in  10  scanout y.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  16  pixel read back.
- mem_addr  out  20  {buffer bit, 19-bit linear address}; registered.
- mem_wdata  out  16  registered write data.
- mem_we  out  1  registered write strobe.
- mem_re  out  1  registered read strobe.
- mem_rdata  in  16  read data, valid the cycle after mem_re.

## Operation
- Address: lin = (y<<9) + (y<<7) + x for H_RES=640 (generic multiply otherwise), 19 bits; mem_addr = {buf, lin}.
- Push (cycle N, program_write=1): if x>=H_RES or y>=V_RES, or count==FIFO_DEPTH (checked before this cycle's pop), the write is discarded and program_dropped pulses at N+1. Otherwise {~frame_sel, lin, data} is pushed; frame_sel is sampled at push time.
- Slot decision, each cycle N, registered onto mem_* at N+1:
  - READ if rd_req=1: mem_re=1, mem_addr={frame_sel, lin(rd_x, rd_y)}.
  - else WRITE if FIFO is non-empty: pop the head; mem_we=1 with its addr/data.
  - else IDLE: mem_we=mem_re=0, mem_addr/mem_wdata hold.
- Read return: mem_re at N+1, mem_rdata captured at N+2, rd_valid/rd_data at N+3. Back-to-back rd_req is legal; each yields its own pulse in order.
- Simultaneous push and pop: count unchanged; FIFO order preserved.
- Starvation: writes progress only in cycles without rd_req. Scanout guarantees blanking gaps; there is no forward-progress timer.
- Reset (asynchronous, any time): FIFO empty, count=0, read pipeline flushed (an in-flight read never raises rd_valid), all outputs 0 except writes_idle=1.

## Timing
- rd_req to rd_valid: exactly 3 cycles, independent of FIFO state.
- program_write to mem_we: min 2 cycles (push at N, pop decision at N+1, mem_we at N+2) when no rd_req.
- program_full updates the cycle after the count changes; the copy engine stalls on it. Writes issued while full are dropped, not held.
- Throughput: 1 memory operation per cycle; 1 push per cycle.

## Test plan
- Reset mid-read: rd_req at cycle 5, reset asserted at 6 -> rd_valid never asserts; after release, all outputs 0 and writes_idle=1.
- Single write: frame_sel=0, write x=3,y=2,data=0xABCD -> two cycles later mem_we=1, mem_addr=0x80503 (bit19=1, 1283), mem_wdata=0xABCD; writes_idle returns to 1.
- Read latency: frame_sel=1, rd_req x=639,y=479, mem model returns 0x1234 -> mem_addr=0xCAFFF with mem_re 1 cycle later; rd_valid=1, rd_data=0x1234 exactly 3 cycles after rd_req.
- Priority and fill: rd_req held for 12 cycles while 10 writes are offered -> no mem_we during the reads; program_full=1 after 8 pushes; 2 program_dropped pulses; the 8 buffered writes drain in order after rd_req drops.
- Out of range: writes at x=640,y=0 and x=0,y=480 -> program_dropped pulses, no mem_we, count stays 0.
- Simultaneous push/pop at count=4 with no rd_req -> count stays 4, popped entry is the oldest.
